// File: rtl/uart_rx_fifo_if.sv
// Register-side bundle of the UART receiver: baud setting, serial input,
// CPU read/clear controls and FIFO/status outputs.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PRESCALE_W = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [PRESCALE_W-1:0] prescale_i;
  logic                  rxd_i;
  logic                  rd_strobe_i;
  logic                  clear_err_i;
  logic [7:0]            data_o;
  logic                  valid_o;
  logic [CW-1:0]         count_o;
  logic                  overrun_o;
  logic                  frame_err_o;
  logic                  busy_o;

  modport master (
    output prescale_i, rxd_i, rd_strobe_i, clear_err_i,
    input  data_o, valid_o, count_o, overrun_o, frame_err_o, busy_o
  );

  modport slave (
    input  prescale_i, rxd_i, rd_strobe_i, clear_err_i,
    output data_o, valid_o, count_o, overrun_o, frame_err_o, busy_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 8x oversampling feeding a first-word-fall-through
// byte FIFO, with sticky overrun and framing error flags.
module uart_rx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned TCW = 7;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                state, state_n;
  logic                  sync1, rxs, rxs_d;
  logic [PRESCALE_W-1:0] p_m1, cnt, cnt_n;
  logic [TCW-1:0]        tc, tc_n, tc_at;
  logic [7:0]            shreg, shreg_n;
  logic                  push_q, push_n, ferr_q, ferr_n;
  logic                  tick;

  logic [7:0]            mem [DEPTH];
  logic [CW-1:0]         wptr, rptr, count;
  logic                  empty, full, do_pop, do_push;
  logic                  overrun, frame_err;

  // Two-stage synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= bus.rxd_i;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign p_m1  = (bus.prescale_i == '0) ? '0 : bus.prescale_i - PRESCALE_W'(1);
  assign tick  = (cnt == '0);
  assign tc_at = tc + TCW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cnt    <= '0;
      tc     <= '0;
      shreg  <= '0;
      push_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      tc     <= tc_n;
      shreg  <= shreg_n;
      push_q <= push_n;
      ferr_q <= ferr_n;
    end
  end

  // tc_at is the tick index being reached on this edge, so sample k lands k*P clocks after START entry
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tc_n    = tc;
    shreg_n = shreg;
    push_n  = 1'b0;
    ferr_n  = 1'b0;

    if (state == IDLE || state == BREAK) begin
      cnt_n = p_m1;
      tc_n  = '0;
    end else if (tick) begin
      cnt_n = p_m1;
      tc_n  = tc_at;
    end else begin
      cnt_n = cnt - PRESCALE_W'(1);
    end

    case (state)
      IDLE:  if (rxs_d && !rxs) state_n = START;
      START: if (tick && tc_at == TCW'(4)) state_n = rxs ? IDLE : DATA;
      DATA: begin
        if (tick && tc_at[2:0] == 3'd4) begin
          shreg_n = {rxs, shreg[7:1]};
          if (tc_at == TCW'(68)) state_n = STOP;
        end
      end
      STOP: begin
        if (tick && tc_at == TCW'(76)) begin
          if (rxs) begin
            push_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign count   = wptr - rptr;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = bus.rd_strobe_i && !empty;
  assign do_push = push_q && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= shreg;
  end

  // Set events take priority over a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr      <= '0;
      rptr      <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + CW'(1);
      if (do_pop)  rptr <= rptr + CW'(1);
      if (push_q && full && !do_pop) overrun <= 1'b1;
      else if (bus.clear_err_i)      overrun <= 1'b0;
      if (ferr_q)                    frame_err <= 1'b1;
      else if (bus.clear_err_i)      frame_err <= 1'b0;
    end
  end

  assign bus.data_o      = empty ? 8'h00 : mem[rptr[AW-1:0]];
  assign bus.valid_o     = !empty;
  assign bus.count_o     = count;
  assign bus.overrun_o   = overrun;
  assign bus.frame_err_o = frame_err;
  assign bus.busy_o      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames are driven bit by bit, the
// expected bytes go into a scoreboard queue and are compared as they are popped.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst_n;

  uart_rx_fifo_if #(.DEPTH(16), .PRESCALE_W(16)) bus ();

  uart_rx_fifo #(.DEPTH(16), .PRESCALE_W(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        t_start = 0;
  int        t_valid = -1;
  logic      valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  // Cycle counter and valid rising-edge timestamp, sampled just after each edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.valid_o === 1'b1 && !valid_prev) t_valid = cyc;
    valid_prev = (bus.valid_o === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Must be called at a negedge; returns at a negedge after the stop bit
  task automatic send_byte(input logic [7:0] b, input int p, input logic stop);
    int bt;
    bt = 8 * p;
    t_start = cyc;
    bus.rxd_i = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd_i = b[i];
      repeat (bt) @(negedge clk);
    end
    bus.rxd_i = stop;
    repeat (bt) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
    check({tag, "_data"}, 32'(bus.data_o), 32'(e));
    bus.rd_strobe_i = 1'b1;
    @(negedge clk);
    bus.rd_strobe_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  32'(bus.data_o),      32'd0);
    check({tag, "_valid"}, 32'(bus.valid_o),     32'd0);
    check({tag, "_count"}, 32'(bus.count_o),     32'd0);
    check({tag, "_ovr"},   32'(bus.overrun_o),   32'd0);
    check({tag, "_ferr"},  32'(bus.frame_err_o), 32'd0);
    check({tag, "_busy"},  32'(bus.busy_o),      32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.prescale_i  = 16'd1;
    bus.rxd_i       = 1'b1;
    bus.rd_strobe_i = 1'b0;
    bus.clear_err_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte at 8 clocks per bit, with push latency measured from the start edge
    t_valid = -1;
    send_byte(8'hA5, 1, 1'b1);
    exp_q.push_back(8'hA5);
    check("a5_latency", 32'(t_valid - t_start), 32'd80);
    check("a5_count", 32'(bus.count_o), 32'd1);
    pop_check("a5");
    check("a5_empty_valid", 32'(bus.valid_o), 32'd0);
    check("a5_empty_data", 32'(bus.data_o), 32'd0);

    // Realistic baud, three frames back to back
    bus.prescale_i = 16'd27;
    send_byte(8'h00, 27, 1'b1); exp_q.push_back(8'h00);
    send_byte(8'hFF, 27, 1'b1); exp_q.push_back(8'hFF);
    send_byte(8'h55, 27, 1'b1); exp_q.push_back(8'h55);
    repeat (4) @(negedge clk);
    check("b2b_count", 32'(bus.count_o), 32'd3);
    check("b2b_ovr", 32'(bus.overrun_o), 32'd0);
    check("b2b_ferr", 32'(bus.frame_err_o), 32'd0);
    for (int i = 0; i < 3; i++) pop_check("b2b");

    // Two-clock glitch: busy from 3 clocks after the edge for exactly 4*P clocks
    bus.prescale_i = 16'd4;
    repeat (4) @(negedge clk);
    bus.rxd_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.rxd_i = 1'b1;
    @(negedge clk);
    check("glitch_busy_start", 32'(bus.busy_o), 32'd1);
    repeat (15) @(negedge clk);
    check("glitch_busy_last", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    check("glitch_busy_end", 32'(bus.busy_o), 32'd0);
    check("glitch_count", 32'(bus.count_o), 32'd0);

    // Low stop bit, then a held-low line, then recovery
    send_byte(8'h3C, 4, 1'b0);
    repeat (200) @(negedge clk);
    check("ferr_set", 32'(bus.frame_err_o), 32'd1);
    check("ferr_count", 32'(bus.count_o), 32'd0);
    check("ferr_break_busy", 32'(bus.busy_o), 32'd1);
    bus.rxd_i = 1'b1;
    repeat (40) @(negedge clk);
    check("ferr_idle_busy", 32'(bus.busy_o), 32'd0);
    check("ferr_idle_count", 32'(bus.count_o), 32'd0);
    send_byte(8'h11, 4, 1'b1);
    exp_q.push_back(8'h11);
    repeat (2) @(negedge clk);
    check("rec_count", 32'(bus.count_o), 32'd1);
    check("rec_ferr_sticky", 32'(bus.frame_err_o), 32'd1);
    pop_check("rec");
    bus.clear_err_i = 1'b1;
    @(negedge clk);
    bus.clear_err_i = 1'b0;
    check("ferr_cleared", 32'(bus.frame_err_o), 32'd0);

    // Overrun: 17 bytes into a 16-deep FIFO
    bus.prescale_i = 16'd1;
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i), 1, 1'b1);
      if (i < 16) exp_q.push_back(8'(i));
    end
    repeat (2) @(negedge clk);
    check("ovr_count", 32'(bus.count_o), 32'd16);
    check("ovr_flag", 32'(bus.overrun_o), 32'd1);
    check("ovr_ferr", 32'(bus.frame_err_o), 32'd0);
    for (int i = 0; i < 16; i++) pop_check("ovr");
    check("ovr_drained_count", 32'(bus.count_o), 32'd0);
    check("ovr_drained_valid", 32'(bus.valid_o), 32'd0);
    bus.clear_err_i = 1'b1;
    @(negedge clk);
    bus.clear_err_i = 1'b0;
    check("ovr_cleared", 32'(bus.overrun_o), 32'd0);

    // Full FIFO with a pop landing exactly on the push edge of a new byte
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h20 + 8'(i), 1, 1'b1);
      exp_q.push_back(8'h20 + 8'(i));
    end
    check("full_count", 32'(bus.count_o), 32'd16);
    fork
      send_byte(8'h30, 1, 1'b1);
      begin
        repeat (79) @(negedge clk);
        pop_check("full_pp");
      end
    join
    exp_q.push_back(8'h30);
    repeat (2) @(negedge clk);
    check("full_pp_ovr", 32'(bus.overrun_o), 32'd0);
    check("full_pp_count", 32'(bus.count_o), 32'd16);
    for (int i = 0; i < 16; i++) pop_check("full_order");
    check("full_drained", 32'(bus.count_o), 32'd0);

    // Reset in the middle of a data phase with bytes queued
    send_byte(8'h01, 1, 1'b1); exp_q.push_back(8'h01);
    send_byte(8'h02, 1, 1'b1); exp_q.push_back(8'h02);
    send_byte(8'h03, 1, 1'b1); exp_q.push_back(8'h03);
    repeat (2) @(negedge clk);
    check("pre_rst_count", 32'(bus.count_o), 32'd3);
    fork
      send_byte(8'h99, 1, 1'b1);
      begin
        repeat (30) @(negedge clk);
        check("mid_busy", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
      end
    join
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("post_rst");
    send_byte(8'h7E, 1, 1'b1);
    exp_q.push_back(8'h7E);
    repeat (2) @(negedge clk);
    check("fresh_count", 32'(bus.count_o), 32'd1);
    pop_check("fresh");
    check("fresh_empty", 32'(bus.valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side counterpart of the system UART transmitter: deserialises 8N1 frames from the FTDI `rxd` pin and buffers them in a small first-word-fall-through FIFO. The CPU drains the FIFO through the memory-mapped IO block. It runs in `clk_sys` and uses the same `prescale` convention as the TX path, so one baud setting serves both directions: `CLK_SYS_HZ / baud / 8`, giving 8 samples per bit.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in bytes. Must be a power of two, ≥ 2.
- `PRESCALE_W`, 16: width of `prescale_i`.

Ports:
- `clk_i`  in  1: system clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `prescale_i`  in  PRESCALE_W: clocks per oversample tick. 0 is treated as 1. Must be stable while a frame is in progress.
- `rxd_i`  in  1: serial input, idle high, asynchronous to `clk_i`.
- `rd_strobe_i`  in  1: pop the FIFO head. Ignored when empty.
- `clear_err_i`  in  1: clear the sticky error flags.
- `data_o`  out  8: FIFO head byte. 8'h00 when empty.
- `valid_o`  out  1: FIFO not empty.
- `count_o`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `overrun_o`  out  1: sticky. A byte was dropped because the FIFO was full.
- `frame_err_o`  out  1: sticky. A stop bit was sampled low.
- `busy_o`  out  1: receiver is not IDLE.

## Operation
- **Input synchroniser.** `rxd_i` passes through a 2-FF synchroniser. Both flops reset to 1. All logic below uses the synchronised value `rxs`.
- **Tick generator.** A down-counter produces a one-cycle `tick` every max(`prescale_i`,1) clocks. The counter is reloaded on start detection so that the first tick falls exactly P clocks later.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. A tick counter `tc` (7 bits) counts ticks since start detection.
  - **IDLE:** falling edge of `rxs` (previous 1, current 0) → START, `tc`=0.
  - **START:** at `tc`=4 (mid start bit), if `rxs`=1 → IDLE (glitch rejected, nothing recorded); otherwise → DATA.
  - **DATA:** sample `rxs` at `tc` = 12, 20, …, 68. Bits are shifted in LSB first. After the 8th sample → STOP.
  - **STOP:** sample at `tc`=76.
    - `rxs`=1: push the byte and go to IDLE.
    - `rxs`=0: set `frame_err_o`, discard the byte, go to BREAK.
  - **BREAK:** wait for `rxs`=1, then → IDLE. No start detection occurs on a held-low line.
- **FIFO.** DEPTH×8 storage, read/write pointers of $clog2(DEPTH)+1 bits that wrap naturally. `data_o` combinationally reflects the head entry.
  - Push while full, with no pop in the same cycle: byte dropped, `overrun_o` set, contents unchanged.
  - Push and pop in the same cycle while full: both take effect; no overrun; count unchanged.
  - Push and pop in the same cycle while empty: push only (the pop is ignored).
- **Error flags.** `clear_err_i` clears both flags. If a set event and `clear_err_i` occur in the same cycle, the set wins.
- **Reset.** `rst_ni` low at any time, including mid-frame:
  - FSM → IDLE, synchroniser → 1, pointers → 0, flags → 0, shift register → 0.
  - Any partially received frame is lost.

## Timing
- **Reset values:** `data_o`=0, `valid_o`=0, `count_o`=0, `overrun_o`=0, `frame_err_o`=0, `busy_o`=0.
- **Start detection:** the FSM enters START 3 clocks after the `rxd_i` falling edge (2 for the synchroniser, 1 for edge detection).
- **Sampling points:** with P = max(`prescale_i`,1), the sample for tick `tc` occurs `tc`·P clocks after start detection. The stop sample is therefore at 76·P clocks.
- **Push latency:** the push is registered on the clock after the stop sample. `valid_o` and `count_o` update on that same edge.
- **Pop:** when `rd_strobe_i` is high and `valid_o`=1 on a rising edge, the next head appears on `data_o` in the following cycle. Pops are one per cycle with no wait states.
- **Error flags:** set on the clock after the failing sample or push.
- **Busy:** `busy_o` is high from START entry until return to IDLE, and is also high in BREAK.
- **Frame length:** a nominal frame is 80·P clocks. The receiver re-arms 4·P clocks before the nominal frame end, tolerating ~±5% baud error.

## Test plan
- **Single byte:** `prescale_i`=1, send 0xA5 at 8 clk/bit → `valid_o` rises 3+76+1 clocks after the start edge, `data_o`=0xA5, `count_o`=1. Then pulse `rd_strobe_i` → `valid_o`=0, `data_o`=0.
- **Realistic baud:** `prescale_i`=27 (115200 baud at 25 MHz), send 0x00, 0xFF, 0x55 back to back → FIFO holds all three in order, no flags set.
- **Glitch and framing error:**
  - 2-clock low pulse on idle `rxd_i` → no push, `busy_o` returns to 0 after 4·P clocks.
  - Send 0x3C with a low stop bit → `frame_err_o`=1, `count_o` unchanged. Hold the line low for 200 clocks → no new frame detected. Release, then send 0x11 → 0x11 received.
  - `clear_err_i` → `frame_err_o`=0.
- **Overrun:** with `DEPTH`=16, send 17 bytes (0x00..0x10) without popping → `count_o`=16, `overrun_o`=1. Pop all → sequence is 0x00..0x0F.
- **Full, push and pop together:** with the FIFO full, assert `rd_strobe_i` exactly on the push cycle of a new byte → `overrun_o` stays 0, `count_o` stays 16, new byte is last in order.
- **Reset mid-frame:** assert `rst_ni`=0 mid-DATA with 3 bytes queued → all outputs return to reset values immediately. After release, a fresh 0x7E is received correctly.
